// File: rtl/sweep_sequencer.sv
// sweep_sequencer: command-level controller driving the DDS frequency sweep / PLL hold.
// Optional macro SWEEP_ABORT_EN: a queued command aborts a sweep in DWELL or STALL.
module sweep_sequencer #(
   parameter int  N_STEPS        = 256,
   parameter int  RESULT_TIMEOUT = 1024,
   localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
   input  logic          clk_50m,
   input  logic          reset,
   input  logic [87:0]   cmd_data,
   input  logic          cmd_empty,
   output logic          cmd_rd_en,
   output logic [31:0]   dds_freq,
   output logic          freq_update,
   input  logic          pd_valid,
   output logic          res_wr_en,
   input  logic          res_almost_full,
   output logic          pll_enable,
   output logic          busy,
   output logic          sweep_done,
   output logic          cmd_err,
   output logic          timeout_err,
   output logic [SW-1:0] step_index
);

   localparam int TW = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
   localparam logic [SW-1:0] LAST_IDX = SW'(N_STEPS - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(RESULT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_DWELL,
      S_WAIT_RES, S_STALL, S_DONE, S_PLL
   } state_t;

   state_t        state;
   logic [31:0]   freq_step;
   logic [31:0]   init_freq;
   logic [15:0]   cps;
   logic [15:0]   dwell_cnt;
   logic [7:0]    mode;
   logic [TW-1:0] to_cnt;
   logic          discard;
   logic          to_hit;
   logic          abort;

   // Pops are combinational so cmd_data lands during FETCH; reset forces them low.
   assign cmd_rd_en  = !reset && !cmd_empty &&
                       (state == S_IDLE || state == S_PLL);
   assign pll_enable = (state == S_PLL) && !cmd_rd_en;
   assign busy       = (state != S_IDLE);
   assign res_wr_en  = (state == S_WAIT_RES) && pd_valid && !discard;
   assign to_hit     = (state == S_WAIT_RES) && !pd_valid &&
                       (to_cnt == TO_LAST);

`ifdef SWEEP_ABORT_EN
   assign abort = !cmd_empty && (state == S_DWELL || state == S_STALL);
`else
   assign abort = 1'b0;
`endif

   // Command decode, dwell timing, result gating and step advance.
   always_ff @(posedge clk_50m or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         freq_step   <= '0;
         init_freq   <= '0;
         cps         <= '0;
         mode        <= '0;
         dwell_cnt   <= '0;
         to_cnt      <= '0;
         discard     <= 1'b0;
         dds_freq    <= '0;
         step_index  <= '0;
         freq_update <= 1'b0;
         sweep_done  <= 1'b0;
         cmd_err     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         freq_update <= 1'b0;
         sweep_done  <= 1'b0;
         cmd_err     <= 1'b0;
         timeout_err <= 1'b0;
         if (abort) begin
            cmd_err <= 1'b1;
            discard <= 1'b0;
            state   <= S_IDLE;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (!cmd_empty) state <= S_FETCH;
               end
               S_FETCH: begin
                  freq_step <= cmd_data[31:0];
                  cps       <= cmd_data[47:32];
                  init_freq <= cmd_data[79:48];
                  mode      <= cmd_data[87:80];
                  state     <= S_DECODE;
               end
               S_DECODE: begin
                  if (mode == 8'h00 && cps != 16'd0) begin
                     dds_freq    <= init_freq;
                     step_index  <= '0;
                     discard     <= 1'b1;
                     freq_update <= 1'b1;
                     dwell_cnt   <= '0;
                     state       <= S_DWELL;
                  end else if (mode == 8'h01) begin
                     dds_freq <= init_freq;
                     state    <= S_PLL;
                  end else begin
                     cmd_err <= 1'b1;
                     state   <= S_IDLE;
                  end
               end
               S_DWELL: begin
                  if (dwell_cnt == cps - 16'd1) begin
                     freq_update <= 1'b1;
                     to_cnt      <= '0;
                     state       <= S_WAIT_RES;
                  end else begin
                     dwell_cnt <= dwell_cnt + 16'd1;
                  end
               end
               S_WAIT_RES: begin
                  if (to_hit) timeout_err <= 1'b1;
                  if (pd_valid || to_hit) begin
                     to_cnt <= '0;
                     if (discard) begin
                        discard <= 1'b0;
                     end else if (step_index == LAST_IDX) begin
                        state <= S_DONE;
                     end else begin
                        dds_freq   <= dds_freq + freq_step;
                        step_index <= step_index + 1'b1;
                        dwell_cnt  <= '0;
                        state      <= res_almost_full ? S_STALL : S_DWELL;
                     end
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
               S_STALL: begin
                  if (!res_almost_full) begin
                     discard     <= 1'b1;
                     freq_update <= 1'b1;
                     dwell_cnt   <= '0;
                     state       <= S_DWELL;
                  end
               end
               S_DONE: begin
                  sweep_done <= 1'b1;
                  state      <= S_IDLE;
               end
               S_PLL: begin
                  if (!cmd_empty) state <= S_FETCH;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Command-level controller between the UART RX command FIFO and the frequency/phase datapath.
- Pops one 88-bit command and decodes the mode: frequency sweep, PLL hold, or reject.
- In sweep mode it steps dds_freq, pulses the phase-detector trigger at each step boundary, and gates phase-detector results into the 80-to-8 output FIFO.
- It stalls the sweep when the output FIFO cannot accept more results, so the UART TX path is never overrun.

Parameters:
- N_STEPS, 256: number of frequency points per sweep; must be >= 1.
- RESULT_TIMEOUT, 1024: cycles to wait for pd_valid after a trigger before skipping that step's result.

Ports:
- clk_50m  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- cmd_data  in  88  command word: [31:0] freq_step, [47:32] cycles_per_step, [79:48] init_freq, [87:80] mode.
- cmd_empty  in  1  command FIFO empty.
- cmd_rd_en  out  1  one-cycle pop; cmd_data is valid the following cycle.
- dds_freq  out  32  DDS tuning word.
- freq_update  out  1  one-cycle pulse to the phase-detector trigger.
- pd_valid  in  1  phase-detector result valid.
- res_wr_en  out  1  write enable to the output FIFO (qualified pd_valid).
- res_almost_full  in  1  output FIFO cannot accept another 80-bit result after the current one.
- pll_enable  out  1  PLL mode active.
- busy  out  1  high in every state except IDLE.
- sweep_done  out  1  one-cycle pulse at sweep completion.
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- timeout_err  out  1  one-cycle pulse when a result timeout occurs.
- step_index  out  $clog2(N_STEPS) (minimum 1)  index of the current step.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset asserted mid-operation aborts immediately, with no done pulse.
- States: IDLE, FETCH, DECODE, DWELL, WAIT_RES, STALL, DONE, PLL.
- IDLE: if !cmd_empty, assert cmd_rd_en for one cycle and go to FETCH.
- FETCH: register all command fields, then go to DECODE.
- DECODE, mode=0x00 with cycles_per_step != 0:
  - dds_freq <= init_freq, step_index <= 0, set the discard flag.
  - Pulse freq_update (flush of stale accumulation), then go to DWELL.
- DECODE, mode=0x01: dds_freq <= init_freq, pll_enable <= 1, go to PLL.
- DECODE, any other mode, or mode 0 with cycles_per_step=0: pulse cmd_err and return to IDLE; dds_freq is unchanged.
- DWELL: stays exactly cycles_per_step cycles (counter 0..cps-1), then goes to WAIT_RES with freq_update high in the first WAIT_RES cycle.
- WAIT_RES: res_wr_en = pd_valid && !discard, combinational in this state only. On pd_valid:
  - If discard is set: clear discard and keep waiting; that result is dropped.
  - Otherwise, if step_index == N_STEPS-1, go to DONE.
  - Otherwise: dds_freq <= dds_freq + freq_step (modulo 2^32, silent wrap) and step_index <= step_index + 1. Then go to STALL if res_almost_full, else to DWELL.
- Result timeout: RESULT_TIMEOUT cycles without pd_valid pulses timeout_err, clears discard, and advances as if a result had arrived, with no write.
- pd_valid outside WAIT_RES is ignored and never written.
- STALL: hold dds_freq. When res_almost_full deasserts:
  - Set discard and pulse freq_update to flush the accumulation integrated during the stall.
  - Then go to DWELL.
- DONE: pulse sweep_done, go to IDLE. dds_freq holds the last point.
- PLL: pll_enable stays high and dds_freq is held. When !cmd_empty:
  - pll_enable <= 0 and cmd_rd_en is pulsed in the same cycle.
  - Go to FETCH.
- Commands arriving during a sweep remain queued until IDLE (unless SWEEP_ABORT_EN).
- Simultaneous events:
  - pd_valid together with the timeout expiry counts as a result.
  - res_almost_full is sampled only at the advance decision.

Optional Feature:
- Macro: SWEEP_ABORT_EN.
- When defined: if !cmd_empty while in DWELL or STALL, the sweep aborts at that cycle.
  - No freq_update and no sweep_done are issued; cmd_err pulses once.
  - Go directly to IDLE, which pops the new command next cycle.
  - WAIT_RES is not interrupted.
- When undefined: sweeps always run to completion and queued commands wait.

Test Plan:
- Sweep, N_STEPS=4, command {mode 00, init 0x0000FFFF, cps 100, step 0x000000FF}:
  - dds_freq sequence 0xFFFF, 0x100FE, 0x101FD, 0x102FC.
  - Exactly 5 freq_update pulses; the first is the flush, then 4 at ~101-cycle spacing.
  - Exactly 4 res_wr_en, one sweep_done.
- PLL command {mode 01, init 0x00000080}: pll_enable=1 and dds_freq=0x80 held. Queueing a mode-0 command afterwards drops pll_enable in the same cycle as cmd_rd_en.
- Bad mode 0x05, then cps=0 with mode 0: two cmd_err pulses, no freq_update, dds_freq unchanged, busy back to 0 within 3 cycles.
- Hold res_almost_full=1 across step 1 for 500 cycles:
  - dds_freq is frozen and no freq_update occurs during the hold.
  - On release: one flush pulse, whose result is not written.
  - Total res_wr_en is still 4.
- pd_valid never asserted, RESULT_TIMEOUT=16, N_STEPS=2: timeout_err pulses 3 times (flush included), res_wr_en never asserts, and sweep_done still pulses. Wrap check: init 0xFFFFFF00, step 0x200 gives second point 0x00000100.
- Assert reset mid-DWELL: all outputs 0 asynchronously and no sweep_done. With SWEEP_ABORT_EN, a command pushed mid-DWELL yields cmd_err, then a new FETCH.
